// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI master and the init/command sequencer:
// transaction mode codes, FSM state encoding and input normalisation helpers.
package lcd_spi_pkg;

    localparam logic [2:0] CMD_WRITE        = 3'd0;
    localparam logic [2:0] CMD_WRITE_DATA   = 3'd1;
    localparam logic [2:0] PIXEL_DATA_WRITE = 3'd2;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StCmd    = 3'd2,
        StData   = 3'd3,
        StPix    = 3'd4,
        StRead   = 3'd5,
        StFinish = 3'd6,
        StGap    = 3'd7
    } state_e;

    // Unknown mode codes fall back to a plain command write.
    function automatic logic [2:0] norm_mode(input logic [2:0] mode);
        return (mode > PIXEL_DATA_WRITE) ? CMD_WRITE : mode;
    endfunction

    function automatic logic [2:0] clamp_num(input logic [3:0] num);
        return (num > 4'd4) ? 3'd4 : num[2:0];
    endfunction

endpackage

// File: rtl/spi_lcd_master_if.sv
// Sequencer, pixel-stream and LCD pin bundle of the SPI LCD master.
// The master modport is the engine's view, slave is the sequencer/panel side.
interface spi_lcd_master_if;

    logic [2:0]  spi_mode;
    logic [7:0]  spi_cmd;
    logic [7:0]  spi_data1;
    logic [7:0]  spi_data2;
    logic [7:0]  spi_data3;
    logic [7:0]  spi_data4;
    logic [3:0]  spi_data_num;
    logic        spi_start;
    logic        spi_read_mode;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        spi_busy;
    logic        lcd_sclk;
    logic        lcd_mosi;
    logic        lcd_cs_n;
    logic        lcd_dc;
    logic        lcd_miso;
    logic [7:0]  read_data;
    logic        read_valid;

    modport master (
        input  spi_mode, spi_cmd, spi_data1, spi_data2, spi_data3, spi_data4,
        input  spi_data_num, spi_start, spi_read_mode, pix_data, pix_valid, lcd_miso,
        output pix_ready, spi_busy, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc,
        output read_data, read_valid
    );

    modport slave (
        output spi_mode, spi_cmd, spi_data1, spi_data2, spi_data3, spi_data4,
        output spi_data_num, spi_start, spi_read_mode, pix_data, pix_valid, lcd_miso,
        input  pix_ready, spi_busy, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc,
        input  read_data, read_valid
    );

endinterface

// File: rtl/spi_lcd_shifter.sv
// SPI mode-0 bit engine: CLK_DIV half-period divider, SCLK generation,
// 8/16-bit MSB-first shift-out, MISO shift-in and completion strobes.
module spi_lcd_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic        len16_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        active_o,
    output logic        done_o,
    output logic        rx_done_o,
    output logic [7:0]  rx_byte_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DivW-1:0] div_q;
    logic [3:0]      bit_q;
    logic [15:0]     sh_q;
    logic [7:0]      rx_q;
    logic            active_q, sclk_q, mosi_q, len16_q;
    logic            half, rise, fall, last;

    assign half      = active_q && (div_q == DivW'(CLK_DIV - 1));
    assign rise      = half && !sclk_q;
    assign fall      = half && sclk_q;
    assign last      = (bit_q == (len16_q ? 4'd15 : 4'd7));
    // done_o fires in the cycle before the final falling edge so a reload lands on it.
    assign done_o    = fall && last;
    assign rx_done_o = rise && (bit_q == 4'd7);
    assign rx_byte_o = {rx_q[6:0], miso_i};
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign active_o  = active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            bit_q    <= 4'd0;
            sh_q     <= 16'h0000;
            rx_q     <= 8'h00;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            len16_q  <= 1'b0;
        end else if (load_i) begin
            div_q    <= '0;
            bit_q    <= 4'd0;
            sh_q     <= data_i;
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= data_i[15];
            len16_q  <= len16_i;
        end else if (active_q) begin
            if (half) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (rise) begin
                rx_q <= rx_byte_o;
            end
            if (fall) begin
                if (last) begin
                    active_q <= 1'b0;
                    mosi_q   <= 1'b0;
                end else begin
                    bit_q  <= bit_q + 4'd1;
                    sh_q   <= {sh_q[14:0], 1'b0};
                    mosi_q <= sh_q[14];
                end
            end
        end
    end

endmodule

// File: rtl/spi_lcd_master.sv
// LCD SPI transmit engine: transaction FSM, byte/pixel counters and CS/DC control.
// Define SPI_READ_EN to build the 8-bit readback phase after the command byte.
module spi_lcd_master
    import lcd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned PIXEL_COUNT = 12800,
    parameter int unsigned CS_IDLE_CYC = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    spi_lcd_master_if.master        bus_io
);

    localparam int unsigned PixW = $clog2(PIXEL_COUNT + 1);

    state_e         state_q, state_d;
    logic [2:0]     mode_q, num_q;
    logic [7:0]     cmd_q;
    logic [3:0][7:0] data_q;
    logic [2:0]     byte_idx_q, byte_idx_d;
    logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           busy_q, busy_d, cs_n_q, cs_n_d, dc_q, dc_d, pix_ready_q, pix_ready_d;
    logic           latch, sh_load, sh_len16, sh_active, sh_done, rx_done;
    logic [15:0]    sh_data;
    logic [7:0]     rx_byte;
    logic           rd_req;

    spi_lcd_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sh_load),
        .data_i    (sh_data),
        .len16_i   (sh_len16),
        .miso_i    (bus_io.lcd_miso),
        .sclk_o    (bus_io.lcd_sclk),
        .mosi_o    (bus_io.lcd_mosi),
        .active_o  (sh_active),
        .done_o    (sh_done),
        .rx_done_o (rx_done),
        .rx_byte_o (rx_byte)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        cs_n_d      = cs_n_q;
        dc_d        = dc_q;
        pix_ready_d = 1'b0;
        byte_idx_d  = byte_idx_q;
        pix_cnt_d   = pix_cnt_q;
        cnt_d       = cnt_q;
        latch       = 1'b0;
        sh_load     = 1'b0;
        sh_data     = 16'h0000;
        sh_len16    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.spi_start) begin
                    latch   = 1'b1;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    dc_d    = (norm_mode(bus_io.spi_mode) == PIXEL_DATA_WRITE);
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (mode_q == PIXEL_DATA_WRITE) begin
                    pix_cnt_d = '0;
                    state_d   = StPix;
                end else begin
                    sh_load = 1'b1;
                    sh_data = {cmd_q, 8'h00};
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (sh_done) begin
                    if (rd_req) begin
                        sh_load = 1'b1;
                        dc_d    = 1'b1;
                        state_d = StRead;
                    end else if (mode_q == CMD_WRITE_DATA && num_q != 3'd0) begin
                        sh_load    = 1'b1;
                        sh_data    = {data_q[0], 8'h00};
                        byte_idx_d = 3'd1;
                        dc_d       = 1'b1;
                        state_d    = StData;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = StFinish;
                    end
                end
            end
            StData: begin
                if (sh_done) begin
                    if (byte_idx_q == num_q) begin
                        cnt_d   = 16'd0;
                        state_d = StFinish;
                    end else begin
                        sh_load    = 1'b1;
                        sh_data    = {data_q[byte_idx_q[1:0]], 8'h00};
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            StPix: begin
                // Next pixel may load as the previous one completes, or whenever the bus is stalled.
                if (!sh_active || sh_done) begin
                    if (pix_cnt_q == PixW'(PIXEL_COUNT)) begin
                        cnt_d   = 16'd0;
                        state_d = StFinish;
                    end else if (bus_io.pix_valid) begin
                        sh_load     = 1'b1;
                        sh_data     = bus_io.pix_data;
                        sh_len16    = 1'b1;
                        pix_ready_d = 1'b1;
                        pix_cnt_d   = pix_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SPI_READ_EN
            StRead: begin
                if (sh_done) begin
                    cnt_d   = 16'd0;
                    state_d = StFinish;
                end
            end
`endif
            StFinish: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    cs_n_d = 1'b1;
                    dc_d   = 1'b0;
                    cnt_d  = 16'd0;
                    if (CS_IDLE_CYC == 0) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == 16'(CS_IDLE_CYC - 1)) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= CMD_WRITE;
            num_q       <= 3'd0;
            cmd_q       <= 8'h00;
            data_q      <= '0;
            byte_idx_q  <= 3'd0;
            pix_cnt_q   <= '0;
            cnt_q       <= 16'd0;
            busy_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            dc_q        <= 1'b0;
            pix_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
            dc_q        <= dc_d;
            pix_ready_q <= pix_ready_d;
            if (latch) begin
                mode_q <= norm_mode(bus_io.spi_mode);
                num_q  <= clamp_num(bus_io.spi_data_num);
                cmd_q  <= bus_io.spi_cmd;
                data_q <= {bus_io.spi_data4, bus_io.spi_data3, bus_io.spi_data2, bus_io.spi_data1};
            end
        end
    end

`ifdef SPI_READ_EN
    logic       rd_req_q, rd_valid_q;
    logic [7:0] rd_data_q;

    assign rd_req = rd_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            if (latch) begin
                rd_req_q <= bus_io.spi_read_mode &&
                            (norm_mode(bus_io.spi_mode) != PIXEL_DATA_WRITE);
            end
            rd_valid_q <= (state_q == StRead) && rx_done;
            if ((state_q == StRead) && rx_done) begin
                rd_data_q <= rx_byte;
            end
        end
    end

    assign bus_io.read_data  = rd_data_q;
    assign bus_io.read_valid = rd_valid_q;
`else
    logic unused_read;

    assign rd_req            = 1'b0;
    assign unused_read       = ^{bus_io.spi_read_mode, rx_done, rx_byte};
    assign bus_io.read_data  = 8'h00;
    assign bus_io.read_valid = 1'b0;
`endif

    assign bus_io.spi_busy  = busy_q;
    assign bus_io.lcd_cs_n  = cs_n_q;
    assign bus_io.lcd_dc    = dc_q;
    assign bus_io.pix_ready = pix_ready_q;

endmodule

// File: tb/tb_spi_lcd_master.sv
// Directed self-checking bench for spi_lcd_master (CLK_DIV=2, PIXEL_COUNT=3, CS_IDLE_CYC=2).
// Read expectations follow SPI_READ_EN, which must match the RTL build.
module tb_spi_lcd_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    spi_lcd_master_if bus ();

    spi_lcd_master #(
        .CLK_DIV     (2),
        .PIXEL_COUNT (3),
        .CS_IDLE_CYC (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.master)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clk edge.
    int   cyc = 0, n_rise = 0, last_t = 0, bad_iv = 0;
    int   cs_low = 0, busy_cyc = 0, pr_cnt = 0, rv_cnt = 0, dc_hi = 0, dc_hi8 = 0;
    logic mosi_v [0:63];
    logic prev_sclk = 1'b0;
    logic [7:0] miso_pat = 8'hA5;

    always @(negedge clk) begin
        cyc++;
        if (bus.lcd_sclk && !prev_sclk) begin
            if (n_rise > 0 && (cyc - last_t) != 4) bad_iv++;
            last_t = cyc;
            if (n_rise < 64) mosi_v[n_rise] = bus.lcd_mosi;
            if (bus.lcd_dc) begin
                dc_hi++;
                if (n_rise < 8) dc_hi8++;
            end
            n_rise++;
        end
        prev_sclk = bus.lcd_sclk;
        if (!bus.lcd_cs_n) cs_low++;
        if (bus.spi_busy) busy_cyc++;
        if (bus.pix_ready) pr_cnt++;
        if (bus.read_valid) rv_cnt++;
    end

    // Panel returns 0xA5 MSB first on the eight clocks that follow the command byte.
    assign bus.lcd_miso = (n_rise >= 8 && n_rise < 16) ? miso_pat[3'(15 - n_rise)] : 1'b0;

    function automatic logic [7:0] get_byte(input int k);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_v[k*8 + i]};
        return b;
    endfunction

    task automatic clear_mon();
        n_rise = 0; bad_iv = 0; cs_low = 0; busy_cyc = 0;
        pr_cnt = 0; rv_cnt = 0; dc_hi = 0; dc_hi8 = 0;
    endtask

    task automatic start_txn(input logic [2:0] mode, input logic [7:0] cmd,
                             input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [7:0] d4,
                             input logic [3:0] num, input logic rmode);
        @(negedge clk);
        bus.spi_mode = mode; bus.spi_cmd = cmd;
        bus.spi_data1 = d1; bus.spi_data2 = d2; bus.spi_data3 = d3; bus.spi_data4 = d4;
        bus.spi_data_num = num; bus.spi_read_mode = rmode; bus.spi_start = 1'b1;
        @(negedge clk);
        bus.spi_start = 1'b0;
        // Inputs are free to change once latched.
        bus.spi_mode = 3'd1; bus.spi_cmd = 8'hFF; bus.spi_data_num = 4'd4; bus.spi_read_mode = 1'b0;
        bus.spi_data1 = 8'h55; bus.spi_data2 = 8'h55; bus.spi_data3 = 8'h55; bus.spi_data4 = 8'h55;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.spi_busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_idle_in_time"}, 32'(k < 5000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pix_ready(input string tag);
        int k = 0;
        @(negedge clk);
        while (!bus.pix_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_pix_ready_seen"}, 32'(k < 300), 32'd1);
    endtask

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.spi_mode = 3'd0; bus.spi_cmd = 8'h00; bus.spi_data_num = 4'd0;
        bus.spi_data1 = 8'h00; bus.spi_data2 = 8'h00; bus.spi_data3 = 8'h00; bus.spi_data4 = 8'h00;
        bus.spi_start = 1'b0; bus.spi_read_mode = 1'b0;
        bus.pix_data = 16'h0000; bus.pix_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {bus.spi_busy, bus.lcd_sclk, bus.lcd_mosi, bus.lcd_cs_n,
                                bus.lcd_dc, bus.pix_ready, bus.read_valid}, 7'b0001000);
        check_eq("reset_rdata", bus.read_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single command byte.
        clear_mon();
        start_txn(3'd0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        wait_idle("m0");
        check_eq("m0_rises", n_rise, 8);
        check_eq("m0_byte", get_byte(0), 8'h29);
        check_eq("m0_dc_high", dc_hi, 0);
        check_eq("m0_cs_low_cycles", cs_low, 35);
        check_eq("m0_busy_cycles", busy_cyc, 37);
        check_eq("m0_bit_spacing", bad_iv, 0);

        // Command plus four parameter bytes.
        clear_mon();
        start_txn(3'd1, 8'h2A, 8'h00, 8'h1A, 8'h00, 8'h6A, 4'd4, 1'b0);
        wait_idle("m1");
        check_eq("m1_rises", n_rise, 40);
        check_eq("m1_byte0", get_byte(0), 8'h2A);
        check_eq("m1_byte1", get_byte(1), 8'h00);
        check_eq("m1_byte2", get_byte(2), 8'h1A);
        check_eq("m1_byte3", get_byte(3), 8'h00);
        check_eq("m1_byte4", get_byte(4), 8'h6A);
        check_eq("m1_dc_cmd", dc_hi8, 0);
        check_eq("m1_dc_data", dc_hi, 32);
        check_eq("m1_no_gap", bad_iv, 0);
        check_eq("m1_cs_low_cycles", cs_low, 163);
        check_eq("m1_busy_cycles", busy_cyc, 165);

        // Parameter count clamps to four.
        clear_mon();
        start_txn(3'd1, 8'h2B, 8'h11, 8'h22, 8'h33, 8'h44, 4'd9, 1'b0);
        wait_idle("clamp");
        check_eq("clamp_rises", n_rise, 40);
        check_eq("clamp_last_byte", get_byte(4), 8'h44);

        // Mode 1 with no parameters behaves as mode 0.
        clear_mon();
        start_txn(3'd1, 8'h29, 8'h11, 8'h22, 8'h33, 8'h44, 4'd0, 1'b0);
        wait_idle("num0");
        check_eq("num0_rises", n_rise, 8);
        check_eq("num0_busy_cycles", busy_cyc, 37);
        check_eq("num0_dc_high", dc_hi, 0);

        // Reserved mode code falls back to command write.
        clear_mon();
        start_txn(3'd5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 4'd4, 1'b0);
        wait_idle("mode5");
        check_eq("mode5_rises", n_rise, 8);
        check_eq("mode5_byte", get_byte(0), 8'h3C);

        // Start re-pulsed mid-transaction is ignored.
        clear_mon();
        start_txn(3'd0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        repeat (10) @(negedge clk);
        bus.spi_start = 1'b1;
        @(negedge clk);
        bus.spi_start = 1'b0;
        wait_idle("restart");
        check_eq("restart_rises", n_rise, 8);
        check_eq("restart_byte", get_byte(0), 8'h29);
        check_eq("restart_busy_cycles", busy_cyc, 37);

        // Pixel burst with a stall before the second pixel.
        clear_mon();
        bus.pix_data = 16'hF800;
        bus.pix_valid = 1'b1;
        start_txn(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        wait_pix_ready("px1");
        bus.pix_valid = 1'b0;
        bus.pix_data = 16'h07E0;
        repeat (80) @(negedge clk);
        check_eq("px_stall_bus", {bus.lcd_sclk, bus.lcd_cs_n, bus.spi_busy, bus.lcd_dc}, 4'b0011);
        check_eq("px_stall_rises", n_rise, 16);
        bus.pix_valid = 1'b1;
        wait_pix_ready("px2");
        bus.pix_data = 16'h001F;
        wait_pix_ready("px3");
        bus.pix_valid = 1'b0;
        wait_idle("px");
        check_eq("px_rises", n_rise, 48);
        check_eq("px_word0", {get_byte(0), get_byte(1)}, 16'hF800);
        check_eq("px_word1", {get_byte(2), get_byte(3)}, 16'h07E0);
        check_eq("px_word2", {get_byte(4), get_byte(5)}, 16'h001F);
        check_eq("px_ready_pulses", pr_cnt, 3);
        check_eq("px_dc_high", dc_hi, 48);

        // Reset in the middle of the command byte.
        clear_mon();
        start_txn(3'd1, 8'h2A, 8'h00, 8'h1A, 8'h00, 8'h6A, 4'd4, 1'b0);
        k = 0;
        while (n_rise < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_reached_bit4", 32'(k < 200), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_abort_bus", {bus.lcd_cs_n, bus.lcd_sclk, bus.spi_busy, bus.lcd_dc}, 4'b1000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        start_txn(3'd0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        wait_idle("post_rst");
        check_eq("post_rst_rises", n_rise, 8);
        check_eq("post_rst_byte", get_byte(0), 8'h29);
        check_eq("post_rst_busy_cycles", busy_cyc, 37);

        // Readback request.
        clear_mon();
        start_txn(3'd0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1);
        wait_idle("rd");
        check_eq("rd_cmd_byte", get_byte(0), 8'h04);
`ifdef SPI_READ_EN
        check_eq("rd_rises", n_rise, 16);
        check_eq("rd_mosi_low", get_byte(1), 8'h00);
        check_eq("rd_data", bus.read_data, 8'hA5);
        check_eq("rd_valid_pulses", rv_cnt, 1);
`else
        check_eq("rd_rises", n_rise, 8);
        check_eq("rd_data", bus.read_data, 8'h00);
        check_eq("rd_valid_pulses", rv_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
